// File: rtl/axi_pkg.sv
// Shared AXI4 read-channel constants and refill-bridge state encodings.
package axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] CACHE_NONE = 4'b0000;
  localparam logic [2:0] PROT_INSN  = 3'b100;

  localparam int         LINE_BEATS = 4;
  localparam logic [7:0] LEN_LINE   = 8'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/icache_axi_rd_bridge.sv
// I-cache refill responder: one 4-beat AXI4 INCR read per miss, assembled
// into a 128-bit line and handed back with a single-cycle ret_valid pulse.
module icache_axi_rd_bridge
  import axi_pkg::*;
#(
  parameter int              ID_W = 4,
  parameter logic [ID_W-1:0] ARID = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_req,
  input  logic [31:0]     rd_addr,
  output logic            ret_valid,
  output logic [127:0]    ret_data,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic            err
);

  localparam logic [1:0] LAST_BEAT = 2'(LINE_BEATS - 1);

  state_t     state, state_n;
  logic [1:0] cnt;
  logic       beat;
  logic       beat_err;

  // Line offset bits are irrelevant: bursts are always line-aligned.
  logic unused_offset;
  assign unused_offset = ^rd_addr[3:0];

  assign arid    = ARID;
  assign arlen   = LEN_LINE;
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;
  assign arcache = CACHE_NONE;
  assign arprot  = PROT_INSN;

  assign arvalid   = (state == AR);
  assign rready    = (state == R);
  assign ret_valid = (state == DONE);

  assign beat     = rready && rvalid;
  assign beat_err = (rresp != RESP_OKAY) || (rid != ARID) || (rlast != (cnt == LAST_BEAT));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (rd_req) state_n = AR;
      AR:      if (arready) state_n = R;
      R:       if (beat && cnt == LAST_BEAT) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      araddr   <= 32'd0;
      ret_data <= 128'd0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && rd_req) begin
        araddr <= {rd_addr[31:4], 4'b0000};
        cnt    <= 2'd0;
      end
      // Completion is counted on accepted beats only; rlast is merely checked.
      if (beat) begin
        ret_data[{cnt, 5'd0} +: 32] <= rdata;
        cnt                         <= cnt + 2'd1;
        if (beat_err) err <= 1'b1;
      end
    end
  end

endmodule
